quota_stream_gen: RTL and testbench

- Multi-channel, sequential successor to the combinational quota mapper.
- Accepts CHANNELS signed QUANT-bit samples through a valid/ready handshake and converts each sample to a quota (ones-count) for a BITSTREAM-long stochastic stream.
- Emits all channel bitstreams in lock-step: one bit per channel per beat, with downstream backpressure.
- Sits between the quantised activation path and the stochastic-computing datapath.

---
 rtl/quota_stream_gen.sv | 193 +++++++++++++++++++
 tb/tb_quota_stream_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quota_stream_gen.sv
// quota_stream_gen: multi-lane sample-to-quota converter and lock-step stochastic
// bitstream generator (Weyl/Bresenham carry pattern), valid/ready on both sides.
// Optional build macro: QUOTA_STREAM_COUNT_CHECK_EN adds per-lane ones counters
// and a sticky count_err output.
module quota_stream_gen #(
   parameter int unsigned BITSTREAM = 64,
   parameter int unsigned QUANT     = 8,
   parameter int unsigned CHANNELS  = 4
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [CHANNELS*QUANT-1:0]                     in_data,
   output logic [CHANNELS*($clog2(BITSTREAM)+1)-1:0]     quota_out,
   output logic                                          bs_valid,
   input  logic                                          bs_ready,
   output logic [CHANNELS-1:0]                           bs_bits,
   output logic [$clog2(BITSTREAM)-1:0]                  bs_idx,
   output logic                                          bs_last,
   output logic                                          busy
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
   ,
   output logic [CHANNELS-1:0]                           count_err
`endif
);

   localparam int unsigned IW = $clog2(BITSTREAM);
   localparam int unsigned W  = IW + 1;
   localparam int unsigned PW = QUANT + IW + 1;
   localparam logic [QUANT-1:0] SIGN_BIT = QUANT'(1) << (QUANT - 1);
   localparam logic [W-1:0]     T_W      = W'(BITSTREAM);
   localparam logic [IW-1:0]    IDX_PEN  = IW'(BITSTREAM - 2);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

   state_t                    state_q, state_d;
   logic [CHANNELS*QUANT-1:0] data_q, data_d;
   logic [CHANNELS*W-1:0]     quota_q, quota_d;
   logic [CHANNELS*IW-1:0]    acc_q, acc_d;
   logic [CHANNELS-1:0]       bits_q, bits_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic                      last_q, last_d;
   logic                      valid_q, valid_d;
   logic                      in_ready_q, in_ready_d;
   logic                      busy_q, busy_d;

   logic [CHANNELS*W-1:0]     s_load;
   logic [CHANNELS-1:0]       load_bit;
   logic [CHANNELS*IW-1:0]    acc_step;
   logic [CHANNELS-1:0]       step_bit;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      logic [QUANT-1:0] u;
      logic [PW-1:0]    prod;
      logic [W-1:0]     s_new;
      logic [W-1:0]     s_cur;
      logic [W-1:0]     sum;
      logic [W-1:0]     nsum;
      logic [IW-1:0]    acc_nxt;

      // Lane datapath: rounded quota from the captured sample, and one carry step of the accumulator
      always_comb begin
         u       = data_q[i*QUANT +: QUANT] ^ SIGN_BIT;
         prod    = (PW'(u) << IW) + PW'(SIGN_BIT);
         s_new   = W'(prod >> QUANT);
         s_cur   = quota_q[i*W +: W];
         sum     = W'(acc_q[i*IW +: IW]) + s_cur;
         acc_nxt = (sum >= T_W) ? IW'(sum - T_W) : IW'(sum);
         nsum    = W'(acc_nxt) + s_cur;
      end

      assign s_load[i*W +: W]     = s_new;
      assign load_bit[i]          = (s_new >= T_W);
      assign acc_step[i*IW +: IW] = acc_nxt;
      assign step_bit[i]          = (nsum >= T_W);
   end

`ifdef QUOTA_STREAM_COUNT_CHECK_EN
   logic [CHANNELS*W-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0]   err_q, err_d;
   logic [W-1:0]          cnt_fin;
`endif

   // Next-state and registered-output logic; the beat on the bus is always the one derived from acc_q
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      quota_d = quota_q;
      acc_d   = acc_q;
      bits_d  = bits_q;
      idx_d   = idx_q;
      last_d  = last_q;
      valid_d = valid_q;
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
      cnt_fin = '0;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               data_d  = in_data;
               state_d = LOAD;
            end
         end
         LOAD: begin
            quota_d = s_load;
            acc_d   = '0;
            bits_d  = load_bit;
            idx_d   = '0;
            last_d  = 1'b0;
            valid_d = 1'b1;
            state_d = STREAM;
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
            cnt_d   = '0;
`endif
         end
         STREAM: begin
            if (bs_ready) begin
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
               for (int i = 0; i < CHANNELS; i++) begin
                  cnt_fin = cnt_q[i*W +: W] + W'(bits_q[i]);
                  cnt_d[i*W +: W] = cnt_fin;
                  if (last_q && (cnt_fin != quota_q[i*W +: W])) err_d[i] = 1'b1;
               end
`endif
               acc_d  = acc_step;
               bits_d = step_bit;
               idx_d  = idx_q + IW'(1);
               last_d = (idx_q == IDX_PEN);
               if (last_q) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  bits_d  = '0;
                  idx_d   = '0;
                  last_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         data_q     <= '0;
         quota_q    <= '0;
         acc_q      <= '0;
         bits_q     <= '0;
         idx_q      <= '0;
         last_q     <= 1'b0;
         valid_q    <= 1'b0;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
         cnt_q      <= '0;
         err_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         quota_q    <= quota_d;
         acc_q      <= acc_d;
         bits_q     <= bits_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         valid_q    <= valid_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign quota_out = quota_q;
   assign bs_valid  = valid_q;
   assign bs_bits   = bits_q;
   assign bs_idx    = idx_q;
   assign bs_last   = last_q;
   assign busy      = busy_q;
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
   assign count_err = err_q;
`endif

endmodule

// File: tb/tb_quota_stream_gen.sv
// tb_quota_stream_gen: randomized self-checking bench for quota_stream_gen against a
// closed-form model (beat j of lane i is 1 iff floor((j+1)s/T) > floor(js/T)).
`timescale 1ns/1ps
module tb_quota_stream_gen;

   localparam int T  = 64;
   localparam int Q  = 8;
   localparam int CH = 4;
   localparam int IW = 6;
   localparam int W  = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [CH*Q-1:0] in_data;
   logic [CH*W-1:0] quota_out;
   logic            bs_valid;
   logic            bs_ready;
   logic [CH-1:0]   bs_bits;
   logic [IW-1:0]   bs_idx;
   logic            bs_last;
   logic            busy;
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
   logic [CH-1:0]   count_err;
`endif

   quota_stream_gen #(.BITSTREAM(T), .QUANT(Q), .CHANNELS(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .quota_out (quota_out),
      .bs_valid  (bs_valid),
      .bs_ready  (bs_ready),
      .bs_bits   (bs_bits),
      .bs_idx    (bs_idx),
      .bs_last   (bs_last),
      .busy      (busy)
`ifdef QUOTA_STREAM_COUNT_CHECK_EN
      ,
      .count_err (count_err)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_s[CH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int quota_of(input int q);
      return ((q + 2**(Q-1)) * T + 2**(Q-1)) / (2**Q);
   endfunction

   function automatic logic [CH-1:0] exp_bits(input int j);
      logic [CH-1:0] r;
      for (int i = 0; i < CH; i++)
         r[i] = (((j + 1) * exp_s[i]) / T) != ((j * exp_s[i]) / T);
      return r;
   endfunction

   function automatic logic [CH*Q-1:0] pack(input int a, input int b, input int c, input int d);
      logic [CH*Q-1:0] r;
      r[0*Q +: Q] = Q'(a);
      r[1*Q +: Q] = Q'(b);
      r[2*Q +: Q] = Q'(c);
      r[3*Q +: Q] = Q'(d);
      return r;
   endfunction

   function automatic int rnd_q();
      return int'($urandom_range(255)) - 128;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      check({tag, "_busy"},     64'(busy),     64'(0));
      check({tag, "_bs_valid"}, 64'(bs_valid), 64'(0));
      check({tag, "_bs_bits"},  64'(bs_bits),  64'(0));
      check({tag, "_bs_idx"},   64'(bs_idx),   64'(0));
      check({tag, "_bs_last"},  64'(bs_last),  64'(0));
      check({tag, "_quota"},    64'(quota_out), 64'(0));
   endtask

   // Send one vector and follow its stream; stall_pct is the bs_ready-low probability,
   // abort_at >= 0 pulses rst when that many beats have been accepted.
   task automatic run_vec(input logic [CH*Q-1:0] data, input int stall_pct, input int abort_at);
      logic [CH*W-1:0] exp_q;
      logic [CH-1:0]   pb;
      logic [IW-1:0]   pidx;
      logic            plast;
      logic            prev_stall;
      int              ones[CH];
      int              j;
      int              cyc;
      for (int i = 0; i < CH; i++) begin
         exp_s[i] = quota_of(int'($signed(data[i*Q +: Q])));
         exp_q[i*W +: W] = W'(exp_s[i]);
         ones[i] = 0;
      end
      cyc = 0;
      while (!in_ready && cyc < 100) begin step(); cyc++; end
      check("in_ready_wait", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = data;
      step();
      in_valid = 1'b0;
      in_data  = $urandom;
      check("load_in_ready", 64'(in_ready), 64'(0));
      check("load_busy",     64'(busy),     64'(1));
      check("load_bs_valid", 64'(bs_valid), 64'(0));
      cyc = 0;
      while (!bs_valid && cyc < 8) begin step(); cyc++; end
      check("first_beat_valid", 64'(bs_valid), 64'(1));
      check("quota", 64'(quota_out), 64'(exp_q));
      j = 0;
      cyc = 0;
      prev_stall = 1'b0;
      pb = '0; pidx = '0; plast = 1'b0;
      while (j < T && cyc < 2000) begin
         if (j == abort_at) begin
            rst = 1'b1;
            bs_ready = 1'b0;
            step();
            rst = 1'b0;
            bs_ready = 1'b1;
            check_reset_state("midrst");
            return;
         end
         if (!bs_valid) begin
            check("valid_dropped", 64'(bs_valid), 64'(1));
            break;
         end
         if (prev_stall) begin
            check("hold_bits", 64'(bs_bits), 64'(pb));
            check("hold_idx",  64'(bs_idx),  64'(pidx));
            check("hold_last", 64'(bs_last), 64'(plast));
         end
         check("beat_bits", 64'(bs_bits), 64'(exp_bits(j)));
         check("beat_idx",  64'(bs_idx),  64'(j));
         check("beat_last", 64'(bs_last), 64'(j == T - 1));
         pb = bs_bits; pidx = bs_idx; plast = bs_last;
         in_valid = (j == 5);
         bs_ready = (int'($urandom_range(99)) >= stall_pct);
         if (bs_ready) begin
            for (int i = 0; i < CH; i++) ones[i] += int'(bs_bits[i]);
            j++;
         end
         prev_stall = !bs_ready;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      bs_ready = 1'b1;
      check("beats_accepted", 64'(j), 64'(T));
      check("end_in_ready", 64'(in_ready), 64'(1));
      check("end_busy",     64'(busy),     64'(0));
      check("end_bs_valid", 64'(bs_valid), 64'(0));
      check("quota_hold",   64'(quota_out), 64'(exp_q));
      for (int i = 0; i < CH; i++) check("ones_count", 64'(ones[i]), 64'(exp_s[i]));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      bs_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      step();
      check_reset_state("reset");

      run_vec(pack(-128, 127, 0, -64), 0, -1);

      for (int q = -128; q < 128; q++)
         run_vec(pack(q, rnd_q(), rnd_q(), rnd_q()), 0, -1);

      for (int k = 0; k < 3; k++)
         run_vec(pack(1, -1, 100, -100), 50, -1);

      for (int k = 0; k < 10; k++)
         run_vec(pack(rnd_q(), rnd_q(), rnd_q(), rnd_q()), int'($urandom_range(80)), -1);

`ifdef QUOTA_STREAM_COUNT_CHECK_EN
      check("count_err_clean", 64'(count_err), 64'(0));
`endif

      run_vec(pack(rnd_q(), rnd_q(), rnd_q(), rnd_q()), 0, 20);
      run_vec(pack(rnd_q(), rnd_q(), rnd_q(), rnd_q()), 30, -1);
      run_vec(pack(-128, 127, 0, -64), 0, -1);

`ifdef QUOTA_STREAM_COUNT_CHECK_EN
      begin
         int cyc;
         check("count_err_clean2", 64'(count_err), 64'(0));
         in_valid = 1'b1;
         in_data  = pack(-128, 127, 0, -128);
         step();
         in_valid = 1'b0;
         for (int k = 0; k < 12; k++) step();
         force dut.acc_q = '0;
         for (int k = 0; k < 10; k++) step();
         release dut.acc_q;
         cyc = 0;
         while (busy && cyc < 200) begin step(); cyc++; end
         check("corrupt_done", 64'(busy), 64'(0));
         check("count_err_set", 64'(count_err), 64'(4'b0100));
         for (int k = 0; k < 5; k++) step();
         check("count_err_sticky", 64'(count_err), 64'(4'b0100));
         run_vec(pack(-128, 127, -128, 127), 0, -1);
         check("count_err_sticky2", 64'(count_err), 64'(4'b0100));
         rst = 1'b1;
         step();
         rst = 1'b0;
         check("count_err_rst", 64'(count_err), 64'(0));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
